// File: rtl/imm_pkg.sv
// Shared types and helpers for the pipelined immediate generator.
// Formats, XLEN legality limits and the sign-extension helper.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_J   = 3'b011,
        IMM_U   = 3'b100,
        IMM_Z   = 3'b101,
        IMM_SH  = 3'b110,
        IMM_RSV = 3'b111
    } imm_src_e;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    // True for the two supported datapath widths.
    function automatic bit xlen_ok(input int x);
        return (x == XLEN_32) || (x == XLEN_64);
    endfunction

    // Sign-extend the low w bits of v to 64 bits.
    function automatic logic [63:0] sext_to(
        input logic [63:0] v,
        input int          w
    );
        logic [63:0] s;
        s = v << (64 - w);
        return 64'($signed(s) >>> (64 - w));
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate extraction for every RISC-V format.
// Reserved code 111 yields zero so the result is never X.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] imm
);

    // Select and extend the immediate field for the requested format.
    always_comb begin
        imm = '0;
        unique case (imm_src_e'(immsrc))
            IMM_I: imm = XLEN'(sext_to(
                64'(instr[31:20]), 12));
            IMM_S: imm = XLEN'(sext_to(
                64'({instr[31:25], instr[11:7]}), 12));
            IMM_B: imm = XLEN'(sext_to(
                64'({instr[31], instr[7],
                     instr[30:25], instr[11:8],
                     1'b0}), 13));
            IMM_J: imm = XLEN'(sext_to(
                64'({instr[31], instr[19:12],
                     instr[20], instr[30:21],
                     1'b0}), 21));
            IMM_U: imm = XLEN'(sext_to(
                64'({instr[31:12], 12'b0}), 32));
            IMM_Z: imm = XLEN'(instr[19:15]);
            IMM_SH: imm = (XLEN == XLEN_32)
                        ? XLEN'(instr[24:20])
                        : XLEN'(instr[25:20]);
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with valid/ready flow control.
// Optional IMM_ILLEGAL_CHK_EN adds out_illegal and err_sticky.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_ILLEGAL_CHK_EN
    ,
    output logic             out_illegal,
    output logic             err_sticky
`endif
);

    if (!xlen_ok(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (STAGES < 1 || STAGES > 2) begin : g_bad_stages
        $error("imm_gen_pipe: STAGES must be 1 or 2");
    end

    logic [XLEN-1:0]  dec_imm;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] rdy;
    logic [XLEN-1:0]  imm_q [STAGES];
    logic [TAG_W-1:0] tag_q [STAGES];
`ifdef IMM_ILLEGAL_CHK_EN
    logic [STAGES-1:0] ill_q;
    logic              dec_ill;
    assign dec_ill = (in_immsrc == IMM_RSV);
`endif

    imm_decode #(
        .XLEN(XLEN)
    ) u_dec (
        .instr  (in_instr),
        .immsrc (in_immsrc),
        .imm    (dec_imm)
    );

    // A stage may load if it or any stage downstream has a hole.
    always_comb begin
        rdy = '0;
        for (int k = 0; k < STAGES; k++) begin
            logic any;
            any = out_ready;
            for (int j = k; j < STAGES; j++) begin
                any = any | ~vld[j];
            end
            rdy[k] = any;
        end
    end

    // Stage registers; data only moves with a valid item.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
`ifdef IMM_ILLEGAL_CHK_EN
            ill_q <= '0;
`endif
            for (int k = 0; k < STAGES; k++) begin
                imm_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    imm_q[0] <= dec_imm;
                    tag_q[0] <= in_tag;
`ifdef IMM_ILLEGAL_CHK_EN
                    ill_q[0] <= dec_ill;
`endif
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        imm_q[k] <= imm_q[k-1];
                        tag_q[k] <= tag_q[k-1];
`ifdef IMM_ILLEGAL_CHK_EN
                        ill_q[k] <= ill_q[k-1];
`endif
                    end
                end
            end
        end
    end

`ifdef IMM_ILLEGAL_CHK_EN
    // Latch any accepted reserved code until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (in_valid && rdy[0] && dec_ill) begin
            err_sticky <= 1'b1;
        end
    end

    assign out_illegal = ill_q[STAGES-1];
`endif

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES-1];
    assign out_imm   = imm_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32/STAGES=1 and XLEN=64/STAGES=2 DUTs.
// Table vectors, random scoreboard, stall and async-reset sequences.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [3:0]  tag;
        int          acc;
    } item_t;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  src;
        logic [63:0] e32;
        logic [63:0] e64;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        vin  [2];
    logic        ir   [2];
    logic        ov   [2];
    logic        rout [2];
    logic [31:0] ins  [2];
    logic [2:0]  src  [2];
    logic [3:0]  tin  [2];
    logic [3:0]  otag [2];
    logic [31:0] o32;
    logic [63:0] o64;
`ifdef IMM_ILLEGAL_CHK_EN
    logic        ill  [2];
    logic        stk  [2];
`endif

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    item_t q0[$];
    item_t q1[$];
    vec_t  tbl[10];

    always #5 clk = ~clk;

    imm_gen_pipe #(
        .XLEN(32), .STAGES(1), .TAG_W(4)
    ) u32 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (vin[0]),
        .in_ready  (ir[0]),
        .in_instr  (ins[0][31:7]),
        .in_immsrc (src[0]),
        .in_tag    (tin[0]),
        .out_valid (ov[0]),
        .out_ready (rout[0]),
        .out_imm   (o32),
        .out_tag   (otag[0])
`ifdef IMM_ILLEGAL_CHK_EN
        ,
        .out_illegal (ill[0]),
        .err_sticky  (stk[0])
`endif
    );

    imm_gen_pipe #(
        .XLEN(64), .STAGES(2), .TAG_W(4)
    ) u64 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (vin[1]),
        .in_ready  (ir[1]),
        .in_instr  (ins[1][31:7]),
        .in_immsrc (src[1]),
        .in_tag    (tin[1]),
        .out_valid (ov[1]),
        .out_ready (rout[1]),
        .out_imm   (o64),
        .out_tag   (otag[1])
`ifdef IMM_ILLEGAL_CHK_EN
        ,
        .out_illegal (ill[1]),
        .err_sticky  (stk[1])
`endif
    );

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] oimm(input int d);
        return d ? o64 : {32'b0, o32};
    endfunction

    // Reference immediate straight from the format definitions.
    function automatic logic [63:0] ref_imm(
        input logic [31:0] i,
        input logic [2:0]  s,
        input int          xl
    );
        logic [63:0] r;
        case (s)
            3'd0: r = 64'($signed(i[31:20]));
            3'd1: r = 64'($signed({i[31:25], i[11:7]}));
            3'd2: r = 64'($signed({i[31], i[7], i[30:25],
                                   i[11:8], 1'b0}));
            3'd3: r = 64'($signed({i[31], i[19:12], i[20],
                                   i[30:21], 1'b0}));
            3'd4: r = 64'($signed({i[31:12], 12'b0}));
            3'd5: r = 64'(i[19:15]);
            3'd6: r = (xl == 32) ? 64'(i[24:20])
                                 : 64'(i[25:20]);
            default: r = 64'd0;
        endcase
        if (xl == 32) r = {32'b0, r[31:0]};
        return r;
    endfunction

    function automatic int qsize(input int d);
        return d ? q1.size() : q0.size();
    endfunction

    function automatic item_t qfront(input int d);
        return d ? q1[0] : q0[0];
    endfunction

    task automatic qpop(input int d);
        if (d != 0) void'(q1.pop_front());
        else        void'(q0.pop_front());
    endtask

    task automatic qpush(input int d, input item_t it);
        if (d != 0) q1.push_back(it);
        else        q0.push_back(it);
    endtask

    logic        stl_p [2];
    logic [63:0] pimm  [2];
    logic [3:0]  ptag  [2];

    // One cycle of scoreboard-checked traffic on both DUTs.
    task automatic step(input bit rnd);
        bit acc [2];
        bit emt [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rnd) begin
                vin[d]  = ($urandom % 4) != 0;
                rout[d] = ($urandom % 3) != 0;
                ins[d]  = $urandom;
                src[d]  = 3'($urandom % 8);
                tin[d]  = 4'($urandom);
            end else begin
                vin[d]  = 1'b0;
                rout[d] = 1'b1;
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            int  stg;
            bit  e_ov;
            stg  = d + 1;
            e_ov = qsize(d) > 0 &&
                   (cyc - qfront(d).acc) >= stg - 1;
            chk(d ? "rnd_in_ready64" : "rnd_in_ready32",
                64'(ir[d]),
                64'(qsize(d) < stg || rout[d]));
            chk(d ? "rnd_out_valid64" : "rnd_out_valid32",
                64'(ov[d]), 64'(e_ov));
            if (ov[d] && qsize(d) > 0) begin
                chk(d ? "rnd_imm64" : "rnd_imm32",
                    oimm(d), qfront(d).imm);
                chk(d ? "rnd_tag64" : "rnd_tag32",
                    64'(otag[d]), 64'(qfront(d).tag));
            end
            if (stl_p[d]) begin
                chk("rnd_hold_imm", oimm(d), pimm[d]);
                chk("rnd_hold_tag", 64'(otag[d]),
                    64'(ptag[d]));
            end
            acc[d]   = vin[d] && ir[d];
            emt[d]   = ov[d] && rout[d];
            stl_p[d] = ov[d] && !rout[d];
            pimm[d]  = oimm(d);
            ptag[d]  = otag[d];
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            item_t it;
            if (emt[d]) qpop(d);
            if (acc[d]) begin
                it.imm = ref_imm(ins[d], src[d],
                                 d ? 64 : 32);
                it.tag = tin[d];
                it.acc = cyc;
                qpush(d, it);
            end
        end
    endtask

    initial begin
        int nxt;
        int exp_t;
        int blk_at;
        bit stp;
        logic [63:0] himm;
        logic [3:0]  htag;

        tbl[0] = '{32'hFFF00093, 3'd0,
                   64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
        tbl[1] = '{32'hFE112E23, 3'd1,
                   64'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC};
        tbl[2] = '{32'h123450B7, 3'd4,
                   64'h12345000, 64'h00000000_12345000};
        tbl[3] = '{32'h000A8073, 3'd5,
                   64'h00000015, 64'h00000000_00000015};
        tbl[4] = '{32'h800000B7, 3'd4,
                   64'h80000000, 64'hFFFFFFFF_80000000};
        tbl[5] = '{32'h02100013, 3'd6,
                   64'h00000001, 64'h00000000_00000021};
        tbl[6] = '{32'h80000063, 3'd2,
                   64'hFFFFF000, 64'hFFFFFFFF_FFFFF000};
        tbl[7] = '{32'h800000EF, 3'd3,
                   64'hFFF00000, 64'hFFFFFFFF_FFF00000};
        tbl[8] = '{32'h00000F63, 3'd2,
                   64'h0000001E, 64'h00000000_0000001E};
        tbl[9] = '{32'hFFFFFFFF, 3'd7,
                   64'h00000000, 64'h00000000_00000000};

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            vin[d] = 0; rout[d] = 1; ins[d] = '0;
            src[d] = '0; tin[d] = '0; stl_p[d] = 0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", 64'(ov[d]), 64'd0);
            chk("rst_out_imm", oimm(d), 64'd0);
            chk("rst_out_tag", 64'(otag[d]), 64'd0);
            chk("rst_in_ready", 64'(ir[d]), 64'd1);
`ifdef IMM_ILLEGAL_CHK_EN
            chk("rst_sticky", 64'(stk[d]), 64'd0);
`endif
        end

        // Directed format table on both widths.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                vin[d] = 1; rout[d] = 1;
                ins[d] = tbl[i].ins; src[d] = tbl[i].src;
                tin[d] = 4'(i);
            end
            @(posedge clk);
            #1;
            vin[0] = 0; vin[1] = 0;
            chk("tbl_valid32", 64'(ov[0]), 64'd1);
            chk("tbl_imm32", oimm(0), tbl[i].e32);
            chk("tbl_tag32", 64'(otag[0]), 64'(i));
            chk("tbl_early64", 64'(ov[1]), 64'd0);
`ifdef IMM_ILLEGAL_CHK_EN
            chk("tbl_illegal32", 64'(ill[0]),
                64'(tbl[i].src == 3'd7));
`endif
            @(posedge clk);
            #1;
            chk("tbl_valid64", 64'(ov[1]), 64'd1);
            chk("tbl_imm64", oimm(1), tbl[i].e64);
            chk("tbl_tag64", 64'(otag[1]), 64'(i));
        end
`ifdef IMM_ILLEGAL_CHK_EN
        chk("tbl_sticky32", 64'(stk[0]), 64'd1);
`endif
        repeat (3) @(negedge clk);

        // Random traffic against the scoreboard.
        repeat (400) step(1'b1);
        repeat (12) step(1'b0);
        chk("drain32", 64'(q0.size()), 64'd0);
        chk("drain64", 64'(q1.size()), 64'd0);

        // STAGES=2 stall: tags 1..6, out_ready low in cycles 3-7.
        nxt = 1; exp_t = 1; blk_at = -1; stp = 0;
        himm = '0; htag = '0;
        vin[0] = 0; rout[0] = 1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            vin[1]  = (nxt <= 6);
            tin[1]  = 4'(nxt);
            ins[1]  = 32'(nxt) << 20;
            src[1]  = 3'd0;
            rout[1] = !(c >= 3 && c <= 7);
            #1;
            if (stp) begin
                chk("stall_hold_imm", o64, himm);
                chk("stall_hold_tag", 64'(otag[1]),
                    64'(htag));
            end
            if (vin[1] && !ir[1] && blk_at < 0)
                blk_at = nxt - 1;
            if (ov[1] && rout[1]) begin
                chk("stall_order", 64'(otag[1]),
                    64'(exp_t));
                chk("stall_imm", o64, 64'(exp_t));
                exp_t++;
            end
            stp  = ov[1] && !rout[1];
            himm = o64;
            htag = otag[1];
            if (vin[1] && ir[1]) nxt++;
        end
        vin[1] = 0;
        chk("stall_accepts_before_block",
            64'(blk_at), 64'd2);
        chk("stall_emitted", 64'(exp_t - 1), 64'd6);

        // Async reset with two items in flight.
        @(negedge clk);
        vin[1] = 1; rout[1] = 0; tin[1] = 4'd9;
        ins[1] = 32'h00900000; src[1] = 3'd7;
        @(negedge clk);
        tin[1] = 4'd10;
        @(negedge clk);
        vin[1] = 0;
        #1;
        chk("pre_rst_full_valid", 64'(ov[1]), 64'd1);
        chk("pre_rst_full_ready", 64'(ir[1]), 64'd0);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(ov[1]), 64'd0);
        #1 reset = 1'b0;
        rout[1] = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("post_rst_valid", 64'(ov[1]), 64'd0);
            chk("post_rst_ready", 64'(ir[1]), 64'd1);
        end
        chk("post_rst_imm", o64, 64'd0);
        chk("post_rst_tag", 64'(otag[1]), 64'd0);
`ifdef IMM_ILLEGAL_CHK_EN
        chk("post_rst_sticky", 64'(stk[1]), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
